csr_timer: RTL and testbench

- CSR-bus slave peripheral: the responder end of the CSR bus that csrbrg masters.
- Decodes its own bank from csr_a[13:10] and holds six registers for two independent 32-bit up-counting timers.
- Each timer raises a one-cycle interrupt pulse on compare match.
- Sits on the CSR bus alongside other slaves. Read data is forced to zero when the bank is not selected, so the slave-to-master data path can be a distributed OR.

---
 rtl/csr_timer_pkg.sv | 14 +
 rtl/csr_timer_unit.sv | 52 +++++
 rtl/csr_timer.sv | 81 ++++++++
 tb/tb_csr_timer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/csr_timer_pkg.sv
// Shared constants for the dual CSR timer: register indices and CTRL bit positions.
package csr_timer_pkg;

    localparam logic [2:0] REG_CTRL0    = 3'd0;
    localparam logic [2:0] REG_COMPARE0 = 3'd1;
    localparam logic [2:0] REG_COUNTER0 = 3'd2;
    localparam logic [2:0] REG_CTRL1    = 3'd3;
    localparam logic [2:0] REG_COMPARE1 = 3'd4;
    localparam logic [2:0] REG_COUNTER1 = 3'd5;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;

endpackage

// File: rtl/csr_timer_unit.sv
// One 32-bit up-counting timer with compare match, autorestart and a registered irq pulse.
module csr_timer_unit
    import csr_timer_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        we_ctrl,
    input  logic        we_compare,
    input  logic        we_counter,
    input  logic [31:0] di,
    output logic        en,
    output logic        ar,
    output logic [31:0] compare,
    output logic [31:0] counter,
    output logic        irq
);

    logic match;

    assign match = en && (counter == compare);

    // CSR writes come last so they override the timer update on the same edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            en      <= 1'b0;
            ar      <= 1'b0;
            compare <= 32'd0;
            counter <= 32'd0;
            irq     <= 1'b0;
        end else begin
            irq <= match;
            if (en) begin
                if (match) begin
                    counter <= 32'd0;
                    if (!ar)
                        en <= 1'b0;
                end else begin
                    counter <= counter + 32'd1;
                end
            end
            if (we_ctrl) begin
                en <= di[CTRL_EN];
                ar <= di[CTRL_AR];
            end
            if (we_compare)
                compare <= di;
            if (we_counter)
                counter <= di;
        end
    end

endmodule

// File: rtl/csr_timer.sv
// CSR-bus slave with two timers; bank decode, write strobes and registered read mux.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq0,
    output logic        irq1
);

    logic        sel;
    logic        wr;
    logic [2:0]  idx;
    logic        en0, ar0, en1, ar1;
    logic [31:0] compare0, counter0, compare1, counter1;
    logic [31:0] rdata;
    logic        unused_addr;

    assign sel         = (csr_a[13:10] == csr_addr);
    assign wr          = sel & csr_we;
    assign idx         = csr_a[2:0];
    assign unused_addr = ^csr_a[9:3];

    csr_timer_unit u_timer0 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .we_ctrl    (wr && idx == REG_CTRL0),
        .we_compare (wr && idx == REG_COMPARE0),
        .we_counter (wr && idx == REG_COUNTER0),
        .di         (csr_di),
        .en         (en0),
        .ar         (ar0),
        .compare    (compare0),
        .counter    (counter0),
        .irq        (irq0)
    );

    csr_timer_unit u_timer1 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .we_ctrl    (wr && idx == REG_CTRL1),
        .we_compare (wr && idx == REG_COMPARE1),
        .we_counter (wr && idx == REG_COUNTER1),
        .di         (csr_di),
        .en         (en1),
        .ar         (ar1),
        .compare    (compare1),
        .counter    (counter1),
        .irq        (irq1)
    );

    always_comb begin
        rdata = 32'd0;
        case (idx)
            REG_CTRL0:    rdata = {30'd0, ar0, en0};
            REG_COMPARE0: rdata = compare0;
            REG_COUNTER0: rdata = counter0;
            REG_CTRL1:    rdata = {30'd0, ar1, en1};
            REG_COMPARE1: rdata = compare1;
            REG_COUNTER1: rdata = counter1;
            default:      rdata = 32'd0;
        endcase
    end

    // Zero when deselected so the bus return path can be a plain OR.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            csr_do <= 32'd0;
        else if (sel)
            csr_do <= rdata;
        else
            csr_do <= 32'd0;
    end

endmodule

// File: tb/tb_csr_timer.sv
// Directed self-checking bench for csr_timer with hand-computed expectations.
module tb_csr_timer;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [13:0] csr_a   = 14'd0;
    logic        csr_we  = 1'b0;
    logic [31:0] csr_di  = 32'd0;
    logic [31:0] csr_do;
    logic        irq0, irq1;

    int total = 0;
    int bad   = 0;

    logic [31:0] rv;

    localparam logic [3:0] BANK = 4'ha;

    csr_timer #(.csr_addr(BANK)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .irq0    (irq0),
        .irq1    (irq1)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        csr_we = 1'b0;
        csr_a  = {4'h0, 7'd0, 3'd7};
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] bank);
        csr_a  = {bank, 7'd0, idx};
        csr_we = 1'b1;
        csr_di = d;
        @(posedge sys_clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [3:0] bank, output logic [31:0] d);
        csr_a  = {bank, 7'd0, idx};
        csr_we = 1'b0;
        @(posedge sys_clk);
        #1;
        d = csr_do;
    endtask

    initial begin
        // reset
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        chk("rst_do", csr_do, 32'd0);
        chk("rst_irq0", {31'd0, irq0}, 32'd0);
        chk("rst_irq1", {31'd0, irq1}, 32'd0);
        sys_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd(3'(i), BANK, rv);
            chk($sformatf("rst_reg%0d", i), rv, 32'd0);
        end

        // one-shot timer 0, compare 5
        wr(3'd1, 32'd5, BANK);
        wr(3'd0, 32'h1, BANK);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t0_irq_k%0d", k), {31'd0, irq0}, (k == 6) ? 32'd1 : 32'd0);
        end
        rd(3'd0, BANK, rv);
        chk("t0_ctrl_cleared", rv, 32'd0);
        rd(3'd2, BANK, rv);
        chk("t0_counter_zero", rv, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t0_no_more_irq", {31'd0, irq0}, 32'd0);
        end

        // autorestart timer 1, period 3
        wr(3'd4, 32'd2, BANK);
        wr(3'd3, 32'h3, BANK);
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("t1_irq_k%0d", k), {31'd0, irq1}, (k % 3 == 0) ? 32'd1 : 32'd0);
        end
        rd(3'd3, BANK, rv);
        chk("t1_ctrl_kept", rv, 32'd3);
        wr(3'd3, 32'h0, BANK);

        // bank decode on writes and reads
        wr(3'd2, 32'hcafebabe, 4'h9);
        rd(3'd2, BANK, rv);
        chk("wr_unselected", rv, 32'd0);
        wr(3'd2, 32'hcafebabe, BANK);
        rd(3'd2, BANK, rv);
        chk("wr_selected", rv, 32'hcafebabe);
        rd(3'd2, 4'h3, rv);
        chk("rd_other_bank", rv, 32'd0);
        rd(3'd6, BANK, rv);
        chk("rd_idx6", rv, 32'd0);

        // read-before-write in the same cycle
        wr(3'd1, 32'd7, BANK);
        csr_a  = {BANK, 7'd0, 3'd1};
        csr_we = 1'b1;
        csr_di = 32'habadface;
        @(posedge sys_clk);
        #1;
        chk("rbw_old", csr_do, 32'd7);
        csr_we = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("rbw_new", csr_do, 32'habadface);

        // wrap-around then match at 3, reset mid-count
        wr(3'd2, 32'hffffffff, BANK);
        wr(3'd1, 32'd3, BANK);
        wr(3'd0, 32'h3, BANK);
        begin
            logic [31:0] exp_cnt [8];
            exp_cnt = '{32'hffffffff, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2};
            for (int k = 1; k <= 8; k++) begin
                rd(3'd2, BANK, rv);
                chk($sformatf("wrap_cnt_k%0d", k), rv, exp_cnt[k-1]);
                chk($sformatf("wrap_irq_k%0d", k), {31'd0, irq0}, (k == 5) ? 32'd1 : 32'd0);
            end
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("midrst_irq0", {31'd0, irq0}, 32'd0);
        chk("midrst_do", csr_do, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), BANK, rv);
            chk($sformatf("midrst_reg%0d", i), rv, 32'd0);
            chk("midrst_irq_quiet", {31'd0, irq0}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
